// File: rtl/rdma_ctyun_fifo_pkg.sv
// Shared types and constants for the show-ahead FIFO read stage.
package rdma_ctyun_fifo_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/rdma_ctyun_skid_buf.sv
// Two-entry valid/ready register slice (output reg + skid reg); with
// USE_SKID=0 the skid entry is never loaded and it collapses to one register.
module rdma_ctyun_skid_buf
  import rdma_ctyun_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit USE_SKID   = 1'b1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output occ_t                  occ
);

  // state | meaning
  // OCC_EMPTY | nothing buffered, out_valid low
  // OCC_ONE   | oldest word in output reg
  // OCC_FULL  | output reg holds oldest, skid reg holds next

  occ_t                  occ_q;
  occ_t                  occ_d;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  xfer;
  logic                  load_out;
  logic                  out_from_skid;
  logic                  load_skid;

  always_comb begin
    xfer          = (occ_q != OCC_EMPTY) && out_ready;
    occ_d         = occ_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (in_valid) begin
          occ_d    = OCC_ONE;
          load_out = 1'b1;
        end
      end
      OCC_ONE: begin
        if (in_valid && xfer) begin
          load_out = 1'b1;
        end else if (in_valid && USE_SKID) begin
          occ_d     = OCC_FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // skid word is older than anything still in the FIFO
        if (xfer) begin
          occ_d         = OCC_ONE;
          out_from_skid = 1'b1;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) occ_q <= OCC_EMPTY;
    else      occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    if (load_out)           out_q <= in_data;
    else if (out_from_skid) out_q <= skid_q;
    if (load_skid)          skid_q <= in_data;
  end

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = out_q;
  assign occ       = occ_q;

  a_no_pop_when_full: assert property (@(posedge clk) disable iff (srst)
    !(in_valid && occ_q == OCC_FULL));
  a_occ_range: assert property (@(posedge clk) disable iff (srst)
    occ_q != 2'd3);

endmodule

// File: rtl/rdma_ctyun_sfifo_rd_stage.sv
// Show-ahead FIFO read stage: pops FIFO words into a registered valid/ready stream.
// Optional RDMA_CTYUN_RD_STAGE_PKT_CNT_EN adds m_last (data MSB) and pkt_cnt.
module rdma_ctyun_sfifo_rd_stage
  import rdma_ctyun_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit USE_SKID   = 1'b1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output occ_t                  occ
`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
  ,
  output logic                  m_last,
  output logic [PKT_CNT_W-1:0]  pkt_cnt
`endif
);

  // With the skid entry the pop ignores m_ready, breaking the comb path to the FIFO.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (USE_SKID) fifo_rd_en = !fifo_empty && (occ != OCC_FULL) && !srst;
    else          fifo_rd_en = !fifo_empty && (!m_valid || m_ready) && !srst;
  end

  rdma_ctyun_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .USE_SKID   (USE_SKID)
  ) u_skid_buf (
    .clk       (clk),
    .srst      (srst),
    .in_valid  (fifo_rd_en),
    .in_data   (fifo_dout),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .occ       (occ)
  );

`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  assign m_last = m_data[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (srst)                             pkt_cnt_q <= '0;
    else if (m_valid && m_ready && m_last) pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_rdma_ctyun_sfifo_rd_stage.sv
// Bench for rdma_ctyun_sfifo_rd_stage: queue-based FIFO and buffer reference model.
module tb_rdma_ctyun_sfifo_rd_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          srst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occ;
`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
  logic          m_last;
  logic [31:0]   pkt_cnt;
  logic [31:0]   pkt_model;
`endif

  always #5 clk = ~clk;

  rdma_ctyun_sfifo_rd_stage #(.DATA_WIDTH(DW), .USE_SKID(1'b1)) dut (
    .clk        (clk),
    .srst       (srst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occ        (occ)
`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
    ,
    .m_last     (m_last),
    .pkt_cnt    (pkt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_pop, n_valid, n_xfer;
  logic [DW-1:0] fifo_q[$];  // contents of the upstream FIFO
  logic [DW-1:0] buf_q[$];   // words held by the stage, oldest first
  logic [DW-1:0] exp_q[$];   // every accepted write, in order, not yet delivered

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: drive inputs at negedge, check, then advance the model across the posedge.
  task automatic cycle(input bit rdy, input bit wr, input logic [DW-1:0] wdata, input bit rst);
    bit exp_rd, exp_xfer;
    @(negedge clk);
    srst       = rst;
    m_ready    = rdy;
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? DW'($urandom) : fifo_q[0];
    #1;
    exp_rd   = !rst && (fifo_q.size() != 0) && (buf_q.size() < 2);
    exp_xfer = (buf_q.size() != 0) && rdy;
    chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
    chk("m_valid", 64'(m_valid), 64'(buf_q.size() != 0));
    chk("occ", 64'(occ), 64'(buf_q.size()));
    if (buf_q.size() != 0) chk("m_data", 64'(m_data), 64'(buf_q[0]));
    if (m_valid && m_ready && exp_q.size() != 0) chk("order", 64'(m_data), 64'(exp_q[0]));
`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
    if (buf_q.size() != 0) chk("m_last", 64'(m_last), 64'(buf_q[0][DW-1]));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(pkt_model));
    if (rst) pkt_model = '0;
    else if (exp_xfer && buf_q[0][DW-1]) pkt_model++;
`endif
    if (fifo_rd_en) n_pop++;
    if (m_valid) n_valid++;
    if (m_valid && m_ready) n_xfer++;
    if (rst) begin
      fifo_q.delete();
      buf_q.delete();
      exp_q.delete();
    end else begin
      if (exp_xfer) begin
        void'(buf_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (exp_rd) buf_q.push_back(fifo_q.pop_front());
      if (wr) preload(wdata);
    end
  endtask

  initial begin
    int cyc, written;
    bit wr;
    srst       = 1'b1;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
    pkt_model  = '0;
`endif
    repeat (2) @(posedge clk);
    cycle(0, 0, '0, 1);

    // burst of 8 with constant ready
    for (int i = 0; i < 8; i++) preload(DW'(32'h10 + i));
    n_pop = 0; n_valid = 0;
    repeat (12) cycle(1, 0, '0, 0);
    chk("t1_pops", 64'(n_pop), 64'd8);
    chk("t1_valid", 64'(n_valid), 64'd8);

    // stalled consumer fills both entries, then drains
    for (int i = 0; i < 4; i++) preload(DW'(32'h20 + i));
    n_pop = 0;
    repeat (6) cycle(0, 0, '0, 0);
    chk("t2_pops", 64'(n_pop), 64'd2);
    chk("t2_occ", 64'(occ), 64'd2);
    chk("t2_head", 64'(m_data), 64'h20);
    n_xfer = 0;
    repeat (8) cycle(1, 0, '0, 0);
    chk("t2_xfers", 64'(n_xfer), 64'd4);

    // random traffic
    written = 0;
    cyc     = 0;
    while ((written < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      wr = (written < 10000) && ($urandom_range(0, 1) == 1);
      if (wr) written++;
      cycle($urandom_range(0, 1) == 1, wr, DW'($urandom), 0);
      cyc++;
    end
    chk("t3_timeout", 64'(cyc < 60000), 64'd1);

    // reset with a full buffer
    for (int i = 0; i < 4; i++) preload(DW'(32'h30 + i));
    repeat (3) cycle(0, 0, '0, 0);
    chk("t4_occ_pre", 64'(occ), 64'd2);
    cycle(0, 0, '0, 1);
    cycle(1, 0, '0, 0);
    chk("t4_valid_post", 64'(m_valid), 64'd0);
    chk("t4_occ_post", 64'(occ), 64'd0);
    preload(DW'(32'hA0));
    preload(DW'(32'hA1));
    n_xfer = 0;
    repeat (5) cycle(1, 0, '0, 0);
    chk("t4_xfers", 64'(n_xfer), 64'd2);

    // empty FIFO, then a single word
    n_valid = 0; n_pop = 0;
    repeat (5) cycle(1, 0, '0, 0);
    chk("t5_idle_valid", 64'(n_valid), 64'd0);
    chk("t5_idle_pops", 64'(n_pop), 64'd0);
    cycle(1, 1, DW'(32'h55), 0);
    n_valid = 0;
    repeat (5) cycle(1, 0, '0, 0);
    chk("t5_single_valid", 64'(n_valid), 64'd1);

`ifdef RDMA_CTYUN_RD_STAGE_PKT_CNT_EN
    cycle(0, 0, '0, 1);
    for (int i = 0; i < 7; i++)
      preload((i == 0 || i == 4 || i == 6) ? DW'(32'h8000_0000 | i) : DW'(i));
    repeat (10) cycle(1, 0, '0, 0);
    chk("pkt3", 64'(pkt_cnt), 64'd3);
    @(negedge clk);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    pkt_model = 32'hFFFF_FFFF;
    preload(DW'(32'h8000_0099));
    repeat (4) cycle(1, 0, '0, 0);
    chk("pkt_wrap", 64'(pkt_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
